// File: rtl/uart_defs.sv
// Shared UART definitions: transmitter state encoding and default line rate,
// so the transmitter and the request receiver agree on baud.
package uart_defs;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// serial bit. Held at zero while 'clear' is high.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_tick = !clear && (count == LAST_COUNT);

    // Wrapping on the tick keeps every bit exactly CLKS_PER_BIT cycles long.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_pair.sv
// Two-byte 8N1 UART transmitter: sends byte0 then byte1 back to back as one
// 20-bit-time frame per accepted start pulse.
module uart_tx_pair
    import uart_defs::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_t state, state_next;
    logic        byte_idx, byte_idx_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [15:0] data_reg, data_next;
    logic        tx_next, busy_next, done_next;
    logic        bit_tick;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == IDLE),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= 1'b0;
            bit_idx  <= 3'd0;
            data_reg <= 16'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            byte_idx <= byte_idx_next;
            bit_idx  <= bit_idx_next;
            data_reg <= data_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Bytes are latched only on an accepted start, so later input changes
    // and starts during a frame cannot disturb the frame in flight.
    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        bit_idx_next  = bit_idx;
        data_next     = data_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    data_next     = {byte1, byte0};
                    byte_idx_next = 1'b0;
                    bit_idx_next  = 3'd0;
                    state_next    = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_tick) begin
                    bit_idx_next = 3'd0;
                    state_next   = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_tick) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                if (bit_tick) begin
                    if (!byte_idx) begin
                        byte_idx_next = 1'b1;
                        state_next    = START_BIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so tx/busy/done
    // change on the same edge as the state and carry no input-to-output path.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        done_next = (state == STOP_BIT) && (state_next == IDLE);
        case (state_next)
            START_BIT: tx_next = 1'b0;
            DATA_BITS: tx_next = data_reg[{byte_idx_next, bit_idx_next}];
            default:   tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_pair.sv
// Self-checking bench for uart_tx_pair: waveforms are compared cycle by cycle
// against an arithmetic frame model and a mid-bit sampling receiver model.
module tb_uart_tx_pair;

    localparam int CPB   = 16;
    localparam int FRAME = 20 * CPB;
    localparam int WIN   = 700;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte0, byte1;
    wire        tx, busy, done;

    logic tx_log   [1:WIN];
    logic busy_log [1:WIN];
    logic done_log [1:WIN];

    int tests_run = 0;
    int failed    = 0;

    uart_tx_pair #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byte0(byte0),
        .byte1(byte1),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clock = ~clock;

    // Expected line level k cycles after the cycle in which start was accepted.
    function automatic logic model_tx(input logic [7:0] b0, input logic [7:0] b1, input int k);
        int bit_time;
        int pos;
        logic [7:0] b;
        if (k < 1 || k > FRAME) return 1'b1;
        bit_time = (k - 1) / CPB;
        pos      = bit_time % 10;
        b        = (bit_time < 10) ? b0 : b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Receiver: frame's first low cycle at 'first', sample the middle of each bit.
    function automatic logic [15:0] rx_decode(input int first);
        logic [15:0] r;
        r = 16'd0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 8; i++) begin
                r[j*8+i] = tx_log[first + j*10*CPB + (i+1)*CPB + CPB/2];
            end
        end
        return r;
    endfunction

    task automatic launch(input logic [7:0] b0, input logic [7:0] b1);
        @(posedge clock);
        #1;
        byte0 = b0;
        byte1 = b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic capture(input int inj_a, input int inj_b, input logic [7:0] nb0, input logic [7:0] nb1);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clock);
            tx_log[k]   = tx;
            busy_log[k] = busy;
            done_log[k] = done;
            if (k == inj_a || k == inj_b) begin
                start = 1'b1;
                byte0 = nb0;
                byte1 = nb1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        byte0 = 8'h00;
        byte1 = 8'h00;
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({tx, busy, done} !== 3'b100) begin
            failed++;
            $display("[TB] FAIL reset_state: tx/busy/done=%b required 100", {tx, busy, done});
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({tx, busy, done} !== 3'b100) begin
            failed++;
            $display("[TB] FAIL after_reset: tx/busy/done=%b required 100", {tx, busy, done});
        end
    endtask

    task automatic test_single(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input int inj_a, input int inj_b);
        logic [15:0] got;
        launch(b0, b1);
        capture(inj_a, inj_b, 8'h11, 8'h22);
        for (int k = 1; k <= WIN; k++) begin
            tests_run++;
            if (tx_log[k] !== model_tx(b0, b1, k) || busy_log[k] !== (k <= FRAME)
                || done_log[k] !== (k == FRAME + 1)) begin
                failed++;
                $display("[TB] FAIL %s cycle %0d: tx/busy/done=%b%b%b required %b%b%b", name, k,
                         tx_log[k], busy_log[k], done_log[k],
                         model_tx(b0, b1, k), (k <= FRAME), (k == FRAME + 1));
            end
        end
        got = rx_decode(1);
        tests_run++;
        if (got !== {b1, b0}) begin
            failed++;
            $display("[TB] FAIL %s decode: got %h required %h", name, got, {b1, b0});
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        logic exp_tx, exp_busy, exp_done;
        launch(8'hA5, 8'h3C);
        capture(FRAME + 1, 0, 8'h55, 8'hAA);
        for (int k = 1; k <= WIN; k++) begin
            exp_tx   = (k <= FRAME + 1) ? model_tx(8'hA5, 8'h3C, k) : model_tx(8'h55, 8'hAA, k - FRAME - 1);
            exp_busy = (k <= FRAME) || (k >= FRAME + 2 && k <= 2*FRAME + 1);
            exp_done = (k == FRAME + 1) || (k == 2*FRAME + 2);
            tests_run++;
            if (tx_log[k] !== exp_tx || busy_log[k] !== exp_busy || done_log[k] !== exp_done) begin
                failed++;
                $display("[TB] FAIL back_to_back cycle %0d: tx/busy/done=%b%b%b required %b%b%b", k,
                         tx_log[k], busy_log[k], done_log[k], exp_tx, exp_busy, exp_done);
            end
        end
        got = rx_decode(FRAME + 2);
        tests_run++;
        if (got !== 16'hAA55) begin
            failed++;
            $display("[TB] FAIL back_to_back decode: got %h required aa55", got);
        end
    endtask

    task automatic test_reset_mid_frame;
        launch(8'($urandom), 8'($urandom));
        repeat (100) @(negedge clock);
        reset = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL mid_reset_async: tx/busy=%b%b required 10", tx, busy);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            tests_run++;
            if ({tx, busy, done} !== 3'b100) begin
                failed++;
                $display("[TB] FAIL mid_reset_quiet cycle %0d: tx/busy/done=%b required 100", k, {tx, busy, done});
            end
        end
        test_single("after_mid_reset", 8'($urandom), 8'($urandom), 0, 0);
    endtask

    task automatic test_idle;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            tests_run++;
            if ({tx, busy, done} !== 3'b100) begin
                failed++;
                $display("[TB] FAIL idle cycle %0d: tx/busy/done=%b required 100", k, {tx, busy, done});
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 3; n++) begin
            test_single("random", 8'($urandom), 8'($urandom), 0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_single("basic", 8'hA5, 8'h3C, 0, 0);
        test_single("edge_bytes", 8'h00, 8'hFF, 0, 0);
        test_single("ignored_start", 8'hA5, 8'h3C, 50, 200);
        test_back_to_back;
        test_reset_mid_frame;
        test_idle;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
